// File: rtl/baby_monitoring_system.sv
// rtl/baby_monitoring_system.sv - three-channel infant sensor threshold monitor with prioritised alert value
module baby_monitoring_system #(
  parameter logic [7:0] HR_MIN          = 8'd60,
  parameter logic [7:0] HR_MAX          = 8'd120,
  parameter logic [7:0] TEMP_MIN        = 8'd85,
  parameter logic [7:0] TEMP_MAX        = 8'd100,
  parameter int         NO_MOTION_COUNT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] heartbeat_data,
  input  logic       heartbeat_valid,
  input  logic [7:0] temperature_data,
  input  logic       temperature_valid,
  input  logic [7:0] motion_data,
  input  logic       motion_valid,
  output logic [7:0] alert_data,
  output logic       heartbeat_alert,
  output logic       temperature_alert,
  output logic       motion_alert
);

  // Widened so that zero_cnt + 1 never wraps before the threshold compare.
  localparam logic [8:0] NO_MOTION_THRESH = 9'(NO_MOTION_COUNT);

  logic [7:0] hb_last_q, hb_last_d;
  logic [7:0] temp_last_q, temp_last_d;
  logic [7:0] mot_last_q, mot_last_d;
  logic [7:0] zero_cnt_q, zero_cnt_d;
  logic       hb_alert_q, hb_alert_d;
  logic       temp_alert_q, temp_alert_d;
  logic       mot_alert_q, mot_alert_d;
  logic [8:0] zero_cnt_next;

  // Per-channel next state: each channel only moves on its own valid strobe.
  always_comb begin
    hb_last_d     = hb_last_q;
    temp_last_d   = temp_last_q;
    mot_last_d    = mot_last_q;
    zero_cnt_d    = zero_cnt_q;
    hb_alert_d    = hb_alert_q;
    temp_alert_d  = temp_alert_q;
    mot_alert_d   = mot_alert_q;
    zero_cnt_next = {1'b0, zero_cnt_q} + 9'd1;

    if (heartbeat_valid) begin
      hb_last_d  = heartbeat_data;
      hb_alert_d = (heartbeat_data < HR_MIN) || (heartbeat_data > HR_MAX);
    end

    if (temperature_valid) begin
      temp_last_d  = temperature_data;
      temp_alert_d = (temperature_data < TEMP_MIN) || (temperature_data > TEMP_MAX);
    end

    if (motion_valid) begin
      mot_last_d = motion_data;
      if (motion_data == 8'd0) begin
        zero_cnt_d  = (zero_cnt_q == 8'hFF) ? 8'hFF : zero_cnt_next[7:0];
        mot_alert_d = (zero_cnt_next >= NO_MOTION_THRESH);
      end else begin
        zero_cnt_d  = 8'd0;
        mot_alert_d = 1'b0;
      end
    end
  end

  // State registers; reset wins over any sample presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hb_last_q    <= 8'd0;
      temp_last_q  <= 8'd0;
      mot_last_q   <= 8'd0;
      zero_cnt_q   <= 8'd0;
      hb_alert_q   <= 1'b0;
      temp_alert_q <= 1'b0;
      mot_alert_q  <= 1'b0;
    end else begin
      hb_last_q    <= hb_last_d;
      temp_last_q  <= temp_last_d;
      mot_last_q   <= mot_last_d;
      zero_cnt_q   <= zero_cnt_d;
      hb_alert_q   <= hb_alert_d;
      temp_alert_q <= temp_alert_d;
      mot_alert_q  <= mot_alert_d;
    end
  end

  assign heartbeat_alert   = hb_alert_q;
  assign temperature_alert = temp_alert_q;
  assign motion_alert      = mot_alert_q;

  // Alert value is taken from registered state only, heartbeat first.
  assign alert_data = hb_alert_q   ? hb_last_q   :
                      temp_alert_q ? temp_last_q :
                      mot_alert_q  ? mot_last_q  : 8'd0;

endmodule

// File: tb/tb_baby_monitoring_system.sv
// tb/tb_baby_monitoring_system.sv - directed self-checking bench for baby_monitoring_system
module tb_baby_monitoring_system;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] heartbeat_data = 8'd0;
  logic       heartbeat_valid = 1'b0;
  logic [7:0] temperature_data = 8'd0;
  logic       temperature_valid = 1'b0;
  logic [7:0] motion_data = 8'd0;
  logic       motion_valid = 1'b0;

  logic [7:0] alert_data_a, alert_data_b;
  logic       hb_alert_a, temp_alert_a, mot_alert_a;
  logic       hb_alert_b, temp_alert_b, mot_alert_b;

  // {heartbeat_alert, temperature_alert, motion_alert, alert_data}
  logic [10:0] obs_a, obs_b;
  assign obs_a = {hb_alert_a, temp_alert_a, mot_alert_a, alert_data_a};
  assign obs_b = {hb_alert_b, temp_alert_b, mot_alert_b, alert_data_b};

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  baby_monitoring_system #(.NO_MOTION_COUNT(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .heartbeat_data(heartbeat_data), .heartbeat_valid(heartbeat_valid),
    .temperature_data(temperature_data), .temperature_valid(temperature_valid),
    .motion_data(motion_data), .motion_valid(motion_valid),
    .alert_data(alert_data_a), .heartbeat_alert(hb_alert_a),
    .temperature_alert(temp_alert_a), .motion_alert(mot_alert_a)
  );

  baby_monitoring_system #(.NO_MOTION_COUNT(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .heartbeat_data(heartbeat_data), .heartbeat_valid(heartbeat_valid),
    .temperature_data(temperature_data), .temperature_valid(temperature_valid),
    .motion_data(motion_data), .motion_valid(motion_valid),
    .alert_data(alert_data_b), .heartbeat_alert(hb_alert_b),
    .temperature_alert(temp_alert_b), .motion_alert(mot_alert_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic hv, input logic [7:0] hd,
                       input logic tv, input logic [7:0] td,
                       input logic mv, input logic [7:0] md);
    heartbeat_valid = hv;   heartbeat_data = hd;
    temperature_valid = tv; temperature_data = td;
    motion_valid = mv;      motion_data = md;
    tick();
    heartbeat_valid = 1'b0; temperature_valid = 1'b0; motion_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs_a !== 11'd0) begin fails++; $display("FAIL reset_a: got %h exp %h", obs_a, 11'd0); end
    checks++;
    if (obs_b !== 11'd0) begin fails++; $display("FAIL reset_b: got %h exp %h", obs_b, 11'd0); end
  endtask

  task automatic test_heartbeat();
    drive(1, 8'd80, 0, 8'd0, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b000, 8'd0}) begin fails++; $display("FAIL hb80: got %h exp %h", obs_a, {3'b000, 8'd0}); end
    drive(1, 8'd130, 0, 8'd0, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b100, 8'd130}) begin fails++; $display("FAIL hb130: got %h exp %h", obs_a, {3'b100, 8'd130}); end
    drive(1, 8'd60, 0, 8'd0, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b000, 8'd0}) begin fails++; $display("FAIL hb60: got %h exp %h", obs_a, {3'b000, 8'd0}); end
    drive(1, 8'd120, 0, 8'd0, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b000, 8'd0}) begin fails++; $display("FAIL hb120: got %h exp %h", obs_a, {3'b000, 8'd0}); end
    drive(1, 8'd121, 0, 8'd0, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b100, 8'd121}) begin fails++; $display("FAIL hb121: got %h exp %h", obs_a, {3'b100, 8'd121}); end
    drive(1, 8'd59, 0, 8'd0, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b100, 8'd59}) begin fails++; $display("FAIL hb59: got %h exp %h", obs_a, {3'b100, 8'd59}); end
    drive(1, 8'd80, 0, 8'd0, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b000, 8'd0}) begin fails++; $display("FAIL hb_clear: got %h exp %h", obs_a, {3'b000, 8'd0}); end
  endtask

  task automatic test_temperature();
    drive(0, 8'd0, 1, 8'd90, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b000, 8'd0}) begin fails++; $display("FAIL t90: got %h exp %h", obs_a, {3'b000, 8'd0}); end
    drive(0, 8'd0, 1, 8'd110, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b010, 8'd110}) begin fails++; $display("FAIL t110: got %h exp %h", obs_a, {3'b010, 8'd110}); end
    drive(0, 8'd0, 1, 8'd84, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b010, 8'd84}) begin fails++; $display("FAIL t84: got %h exp %h", obs_a, {3'b010, 8'd84}); end
    drive(0, 8'd0, 1, 8'd85, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b000, 8'd0}) begin fails++; $display("FAIL t85: got %h exp %h", obs_a, {3'b000, 8'd0}); end
    drive(0, 8'd0, 1, 8'd101, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b010, 8'd101}) begin fails++; $display("FAIL t101: got %h exp %h", obs_a, {3'b010, 8'd101}); end
    drive(0, 8'd0, 1, 8'd100, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b000, 8'd0}) begin fails++; $display("FAIL t100: got %h exp %h", obs_a, {3'b000, 8'd0}); end
  endtask

  task automatic test_motion();
    drive(0, 8'd0, 0, 8'd0, 1, 8'd0);
    checks++;
    if (obs_a !== {3'b001, 8'd0}) begin fails++; $display("FAIL mot0_a: got %h exp %h", obs_a, {3'b001, 8'd0}); end
    checks++;
    if (obs_b !== {3'b000, 8'd0}) begin fails++; $display("FAIL mot0_b: got %h exp %h", obs_b, {3'b000, 8'd0}); end
    drive(0, 8'd0, 0, 8'd0, 1, 8'd1);
    checks++;
    if (obs_a !== {3'b000, 8'd0}) begin fails++; $display("FAIL mot1_a: got %h exp %h", obs_a, {3'b000, 8'd0}); end
    // counter restarted by the nonzero sample: three fresh zeros needed on the N=3 instance
    for (int i = 1; i <= 3; i++) begin
      drive(0, 8'd0, 0, 8'd0, 1, 8'd0);
      checks++;
      if (mot_alert_b !== (i == 3)) begin fails++; $display("FAIL mot_cnt3_zero%0d: got %b exp %b", i, mot_alert_b, (i == 3)); end
    end
    checks++;
    if (obs_a !== {3'b001, 8'd0}) begin fails++; $display("FAIL mot_a_hold: got %h exp %h", obs_a, {3'b001, 8'd0}); end
    drive(0, 8'd0, 0, 8'd0, 1, 8'd7);
    checks++;
    if ({mot_alert_a, mot_alert_b} !== 2'b00) begin fails++; $display("FAIL mot_clear: got %b exp %b", {mot_alert_a, mot_alert_b}, 2'b00); end
  endtask

  task automatic test_priority();
    drive(1, 8'd130, 1, 8'd110, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b110, 8'd130}) begin fails++; $display("FAIL prio_both: got %h exp %h", obs_a, {3'b110, 8'd130}); end
    drive(1, 8'd80, 0, 8'd0, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b010, 8'd110}) begin fails++; $display("FAIL prio_temp: got %h exp %h", obs_a, {3'b010, 8'd110}); end
    drive(1, 8'd200, 1, 8'd90, 1, 8'd0);
    checks++;
    if (obs_a !== {3'b101, 8'd200}) begin fails++; $display("FAIL prio_hb_mot: got %h exp %h", obs_a, {3'b101, 8'd200}); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      heartbeat_data = 8'd10 + 8'(i);
      temperature_data = 8'd250;
      motion_data = 8'd1;
      tick();
      checks++;
      if (obs_a !== {3'b101, 8'd200}) begin fails++; $display("FAIL hold%0d: got %h exp %h", i, obs_a, {3'b101, 8'd200}); end
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 8'd0, 1, 8'd110, 0, 8'd0);
    reset = 1'b1;
    drive(1, 8'd250, 1, 8'd20, 1, 8'd0);
    reset = 1'b0;
    checks++;
    if (obs_a !== 11'd0) begin fails++; $display("FAIL rst_mid_a: got %h exp %h", obs_a, 11'd0); end
    checks++;
    if (obs_b !== 11'd0) begin fails++; $display("FAIL rst_mid_b: got %h exp %h", obs_b, 11'd0); end
    tick();
    checks++;
    if (obs_a !== 11'd0) begin fails++; $display("FAIL rst_discard: got %h exp %h", obs_a, 11'd0); end
    drive(1, 8'd45, 0, 8'd0, 0, 8'd0);
    checks++;
    if (obs_a !== {3'b100, 8'd45}) begin fails++; $display("FAIL rst_first: got %h exp %h", obs_a, {3'b100, 8'd45}); end
  endtask

  initial begin
    test_reset();
    test_heartbeat();
    test_temperature();
    test_motion();
    test_priority();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/baby_monitoring_system.md
# baby_monitoring_system

Sensor-threshold monitor for an infant-care controller. It accepts three independent 8-bit sample streams (heartbeat, temperature, motion), each qualified by a one-cycle valid strobe, and classifies every accepted sample against configurable limits. It drives one alert flag per channel plus an 8-bit alert value for the downstream display/alarm logic. It sits between the sensor front-end samplers and the alarm/notification unit.

## Interface
- HR_MIN, 8'd60, lowest normal heartbeat (inclusive)
- HR_MAX, 8'd120, highest normal heartbeat (inclusive)
- TEMP_MIN, 8'd85, lowest normal temperature code (inclusive)
- TEMP_MAX, 8'd100, highest normal temperature code (inclusive)
- NO_MOTION_COUNT, 1, consecutive zero-motion samples before motion alert (1..255)
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high reset
- heartbeat_data  in  8  heartbeat sample (bpm, unsigned)
- heartbeat_valid  in  1  heartbeat_data valid this cycle
- temperature_data  in  8  temperature sample (unsigned code)
- temperature_valid  in  1  temperature_data valid this cycle
- motion_data  in  8  motion sample; 0 = no movement, nonzero = movement
- motion_valid  in  1  motion_data valid this cycle
- alert_data  out  8  sample value of highest-priority active alert, 0 if none
- heartbeat_alert  out  1  last heartbeat sample outside [HR_MIN,HR_MAX]
- temperature_alert  out  1  last temperature sample outside [TEMP_MIN,TEMP_MAX]
- motion_alert  out  1  NO_MOTION_COUNT consecutive zero-motion samples seen

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- Each channel holds a registered last-sample (hb_last, temp_last, mot_last) and its alert flag; all update only on cycles with that channel's valid high.
- Heartbeat: on heartbeat_valid, hb_last <= heartbeat_data; heartbeat_alert <= (data < HR_MIN) || (data > HR_MAX). Boundary values HR_MIN/HR_MAX are normal.
- Temperature: same rule with TEMP_MIN/TEMP_MAX.
- Motion: 8-bit saturating counter zero_cnt. On motion_valid with data==0: zero_cnt increments (saturate at 255); motion_alert <= (zero_cnt+1 >= NO_MOTION_COUNT). On motion_valid with data!=0: zero_cnt <= 0, motion_alert <= 0.
- Alerts are level, not sticky: a subsequent normal sample clears the flag.
- alert_data is combinational from the registered state: heartbeat_alert ? hb_last : temperature_alert ? temp_last : motion_alert ? mot_last : 8'd0. Priority heartbeat > temperature > motion.
- Valid low: all channel state holds; data inputs ignored.
- Simultaneous valids on several channels: all channels update independently in the same cycle.
- All comparisons unsigned, 8-bit; no arithmetic wrap except the saturating zero_cnt.

## Timing
- Reset (sampled at rising edge with reset=1): all alert flags 0, alert_data 0, hb_last/temp_last/mot_last 0, zero_cnt 0. Reset has priority over any valid in the same cycle; a sample presented during reset is discarded.
- Latency: sample accepted at rising edge N (valid high); alert flags and alert_data reflect it after edge N, i.e. one cycle latency, no combinational input-to-output path.
- No back-pressure: every valid cycle is accepted; back-to-back valids on one channel are each evaluated, the later overwriting the earlier.
- Reset asserted mid-operation clears all state on the next edge; first sample after deassertion is evaluated normally.

## Test plan
- Reset, then heartbeat 80 valid one cycle -> heartbeat_alert 0, alert_data 0; then heartbeat 130 -> heartbeat_alert 1, alert_data 130; then heartbeat 60 and 120 -> alert 0 (boundaries normal), 59 -> alert 1.
- Temperature 90 -> temperature_alert 0; temperature 110 -> temperature_alert 1, alert_data 110 (heartbeat normal); temperature 84 -> alert 1, alert_data 84.
- Motion 0 valid (NO_MOTION_COUNT=1) -> motion_alert 1, alert_data 0; motion 1 -> motion_alert 0, zero_cnt 0. With NO_MOTION_COUNT=3: two zeros -> 0, third -> 1.
- Priority: heartbeat 130 and temperature 110 valid same cycle -> both alerts 1, alert_data 130; then heartbeat 80 -> alert_data 110.
- Valid low with changing data -> outputs hold; reset asserted while alerts active -> all outputs 0 after next edge, sample with valid during reset ignored.
